// File: rtl/ysyx_23060096_pkg.sv
// ysyx_23060096_pkg: state encoding and wait-counter width shared by the multicycle controller.
package ysyx_23060096_pkg;
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;
    localparam int TMO_W = 8;
endpackage

// File: rtl/ysyx_23060096_wait_timer.sv
// ysyx_23060096_wait_timer: counts consecutive stalled bus-wait cycles and flags expiry.
module ysyx_23060096_wait_timer
    import ysyx_23060096_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    output logic expired
);
    logic [TMO_W-1:0] cnt;
    // Expiry fires on the LIMIT-th stalled cycle; any non-stalled cycle (ack or state change) clears.
    assign expired = stall && (cnt == TMO_W'(LIMIT - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else cnt <= stall ? cnt + 1'b1 : '0;
    end
endmodule

// File: rtl/ysyx_23060096_multicycle_ctrl.sv
// ysyx_23060096_multicycle_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with retire counter.
// Optional bus timeout enabled by defining YSYX_23060096_BUS_TIMEOUT_EN.
module ysyx_23060096_multicycle_ctrl
    import ysyx_23060096_pkg::*;
#(
    parameter int unsigned INSTRET_W   = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 ifu_req,
    input  logic                 ifu_gnt,
    output logic                 ir_we,
    input  logic                 dec_regwr,
    input  logic                 dec_memtoreg,
    input  logic                 dec_memwr,
    input  logic                 dec_ebreak,
    output logic                 lsu_req,
    output logic                 lsu_we,
    input  logic                 lsu_ack,
    output logic                 rf_we,
    output logic                 pc_we,
    output logic                 halted,
    output logic                 err,
    output logic [INSTRET_W-1:0] instret
);
    state_e state;
    logic   tmo;
`ifdef YSYX_23060096_BUS_TIMEOUT_EN
    logic stall;
    assign stall = (state == ST_FETCH && !ifu_gnt) || (state == ST_MEM && !lsu_ack);
    ysyx_23060096_wait_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .stall   (stall),
        .expired (tmo)
    );
`else
    assign tmo = 1'b0 && (TIMEOUT_CYC > 0);
`endif
    // Gating with rst_n keeps the fetch request low while reset is held.
    assign ifu_req = rst_n && state == ST_FETCH;
    assign ir_we   = ifu_req && ifu_gnt;
    assign lsu_req = state == ST_MEM;
    assign lsu_we  = lsu_req && dec_memwr;
    assign rf_we   = state == ST_WB && dec_regwr && !dec_memwr;
    assign pc_we   = state == ST_WB;
    assign halted  = state == ST_HALT;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_FETCH;
            err     <= 1'b0;
            instret <= '0;
        end else if (tmo) begin
            state <= ST_HALT;
            err   <= 1'b1;
        end else begin
            unique case (state)
                ST_FETCH:  state <= ifu_gnt ? ST_DECODE : ST_FETCH;
                ST_DECODE: state <= dec_ebreak ? ST_HALT : ST_EXEC;
                ST_EXEC:   state <= (dec_memtoreg || dec_memwr) ? ST_MEM : ST_WB;
                ST_MEM:    state <= lsu_ack ? ST_WB : ST_MEM;
                ST_WB: begin
                    state   <= ST_FETCH;
                    instret <= instret + 1'b1;
                end
                default:   state <= ST_HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_23060096_multicycle_ctrl.sv
// tb_ysyx_23060096_multicycle_ctrl: directed plus randomized instruction streams against a per-instruction cycle model.
module tb_ysyx_23060096_multicycle_ctrl;
    logic clk = 1'b0, rst_n = 1'b0;
    logic ifu_gnt = 1'b0, lsu_ack = 1'b0;
    logic dec_regwr = 1'b0, dec_memtoreg = 1'b0, dec_memwr = 1'b0, dec_ebreak = 1'b0;
    logic ifu_req, ir_we, lsu_req, lsu_we, rf_we, pc_we, halted, err;
    logic [3:0] instret;
    int n_chk = 0, n_pass = 0, retired = 0;

    always #5 clk = ~clk;

    ysyx_23060096_multicycle_ctrl #(.INSTRET_W(4), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n), .ifu_req(ifu_req), .ifu_gnt(ifu_gnt), .ir_we(ir_we),
        .dec_regwr(dec_regwr), .dec_memtoreg(dec_memtoreg), .dec_memwr(dec_memwr),
        .dec_ebreak(dec_ebreak), .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_ack(lsu_ack),
        .rf_we(rf_we), .pc_we(pc_we), .halted(halted), .err(err), .instret(instret)
    );

    // Expected vector bit order: {ifu_req, ir_we, lsu_req, lsu_we, rf_we, pc_we, halted, err}
    task automatic check(input string tag, input logic [7:0] e);
        logic [7:0] o;
        logic [3:0] ei;
        o  = {ifu_req, ir_we, lsu_req, lsu_we, rf_we, pc_we, halted, err};
        ei = 4'(retired % 16);
        n_chk++;
        assert (o === e && instret === ei) n_pass++;
        else $error("FAIL %s t=%0t outs=%b instret=%0d expected outs=%b instret=%0d", tag, $time, o, instret, e, ei);
    endtask

    task automatic step(input logic g, input logic a, input logic [7:0] e, input string tag);
        ifu_gnt = g;
        lsu_ack = a;
        @(negedge clk);
        check(tag, e);
        @(posedge clk);
        #1;
    endtask

    // kind: 0 alu, 1 load, 2 store, 3 ebreak; gd/ad = stall cycles before gnt/ack
    task automatic run_inst(input int kind, input int gd, input int ad, input logic rw);
        logic st;
        st = (kind == 2);
        dec_regwr = rw; dec_memtoreg = (kind == 1); dec_memwr = st; dec_ebreak = (kind == 3);
        for (int i = 0; i < gd; i++) step(1'b0, 1'($urandom), 8'b1000_0000, "fetch_wait");
        step(1'b1, 1'($urandom), 8'b1100_0000, "fetch_gnt");
        step(1'($urandom), 1'($urandom), 8'h00, "decode");
        if (kind == 3) return;
        step(1'($urandom), 1'($urandom), 8'h00, "exec");
        if (kind == 1 || kind == 2) begin
            for (int i = 0; i < ad; i++) step(1'($urandom), 1'b0, {2'b00, 1'b1, st, 4'b0000}, "mem_wait");
            step(1'($urandom), 1'b1, {2'b00, 1'b1, st, 4'b0000}, "mem_ack");
        end
        step(1'($urandom), 1'($urandom), {4'b0000, rw & ~st, 1'b1, 2'b00}, "wb");
        retired++;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", 8'h00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_inst(0, 0, 0, 1'b1);
        run_inst(1, 0, 3, 1'b1);
        run_inst(2, 0, 0, 1'b0);
        run_inst(0, 0, 0, 1'b0);
        for (int n = 0; n < 40; n++)
            run_inst(int'($urandom_range(2, 0)), int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), 1'($urandom));
        run_inst(3, 1, 0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'b0000_0010, "halt");
        // Reset out of HALT, then abort a load mid-MEM with an asynchronous reset.
        rst_n = 1'b0;
        retired = 0;
        #1 check("halt_reset", 8'h00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        dec_regwr = 1'b1; dec_memtoreg = 1'b1; dec_memwr = 1'b0; dec_ebreak = 1'b0;
        step(1'b1, 1'b0, 8'b1100_0000, "ld_fetch");
        step(1'b0, 1'b0, 8'h00, "ld_decode");
        step(1'b0, 1'b0, 8'h00, "ld_exec");
        step(1'b0, 1'b0, 8'b0010_0000, "ld_mem");
        #2 rst_n = 1'b0;
        #1 check("mem_async_reset", 8'h00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b0, 1'b0, 8'b1000_0000, "post_reset_fetch");
`ifdef YSYX_23060096_BUS_TIMEOUT_EN
        run_inst(0, 2, 0, 1'b1);
        run_inst(1, 3, 3, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'b1000_0000, "tmo_wait");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'b0000_0011, "tmo_halt");
`else
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 8'b1000_0000, "no_tmo_wait");
        run_inst(0, 0, 0, 1'b1);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
